// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative tag store: line entry,
// sweep FSM states and elaboration-time width functions.
package cache_pkg;

  // Widest tag any instance may need; narrower tags are zero-extended.
  localparam int MAX_TAG_W = 32;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [MAX_TAG_W-1:0] tag;
  } line_t;

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  // ceil(log2(n)) with a floor of 1, so a direct-mapped cache keeps a 1-bit way index
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: picks the victim way from the current node bits
// and produces the node bits after touching access_way.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [((WAYS > 1) ? WAYS - 1 : 1)-1:0] plru_bits,
  input  logic [clog2_min1(WAYS)-1:0]            access_way,
  output logic [clog2_min1(WAYS)-1:0]            victim,
  output logic [((WAYS > 1) ? WAYS - 1 : 1)-1:0] next_bits
);

  localparam int VW     = clog2_min1(WAYS);
  localparam int LEVELS = (WAYS > 1) ? $clog2(WAYS) : 0;

  // Heap layout: node n at level l covers position p = n + 1 - 2^l.
  // A node bit of 0 points the victim walk into the lower half.
  always_comb begin
    logic bit_v;
    victim    = '0;
    next_bits = plru_bits;
    bit_v     = 1'b0;
    for (int l = 0; l < LEVELS; l++) begin
      bit_v = 1'b0;
      for (int p = 0; p < (1 << l); p++) begin
        if ((victim >> (VW - l)) == VW'(p)) bit_v = plru_bits[(1 << l) - 1 + p];
      end
      victim[VW-1-l] = bit_v;
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((access_way >> (VW - l)) == VW'(p))
          next_bits[(1 << l) - 1 + p] = ~access_way[VW-1-l];
      end
    end
  end

endmodule

// File: rtl/cache_tag_nway.sv
// N-way set-associative tag store: combinational hit/miss, tree-PLRU victim
// selection, dirty tracking and a one-set-per-cycle invalidate-all sweep.
module cache_tag_nway
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 6,
  parameter int ADDR_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        cached,
  input  logic                        sram_en,
  input  logic [3:0]                  sram_wen,
  input  logic [ADDR_W-1:0]           sram_addr,
  input  logic                        refresh,
  input  logic                        inv_all_req,
  output logic                        inv_busy,
  output logic                        stallreq,
  output logic                        miss,
  output logic [WAYS-1:0]             hit,
  output logic [clog2_min1(WAYS)-1:0] victim,
  output logic [ADDR_W-1:0]           axi_raddr,
  output logic                        write_back,
  output logic [ADDR_W-1:0]           axi_waddr
);

  localparam int TAG_W = calc_tag_w(ADDR_W, INDEX_W, OFFSET_W);
  localparam int VW    = clog2_min1(WAYS);
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int SETS  = 1 << INDEX_W;

  line_t        lines [WAYS][SETS];
  logic [PW-1:0] plru [SETS];

  sweep_state_t       state, state_next;
  logic [INDEX_W-1:0] sweep_cnt, cnt_next;
  logic               sweep_clear;

  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   index;
  logic [MAX_TAG_W-1:0] addr_tag_ext;
  logic                 lookup_ok;
  logic [VW-1:0]        hit_way;
  logic [VW-1:0]        access_way;
  logic [PW-1:0]        next_bits;
  logic                 do_refill;
  line_t                vline;
  line_t                new_line;

  assign addr_tag     = sram_addr[ADDR_W-1 -: TAG_W];
  assign index        = sram_addr[OFFSET_W +: INDEX_W];
  assign addr_tag_ext = MAX_TAG_W'(addr_tag);

  assign inv_busy  = (state == ST_SWEEP);
  assign lookup_ok = ~flush & ~inv_busy & cached & sram_en;

  always_comb begin
    hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = lookup_ok & lines[w][index].valid & (lines[w][index].tag == addr_tag_ext);
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit[w]) hit_way = hit_way | VW'(w);
    end
  end

  assign miss     = lookup_ok & ~|hit;
  assign stallreq = miss | inv_busy;

  // Refill targets the victim; otherwise the hitting way is the one touched.
  assign do_refill  = refresh & cached & (state == ST_IDLE);
  assign access_way = do_refill ? victim : hit_way;

  plru_tree #(
    .WAYS(WAYS)
  ) u_plru (
    .plru_bits (plru[index]),
    .access_way(access_way),
    .victim    (victim),
    .next_bits (next_bits)
  );

  assign vline      = lines[victim][index];
  assign write_back = miss & vline.valid & vline.dirty;
  assign axi_waddr  = {vline.tag[TAG_W-1:0], index, {OFFSET_W{1'b0}}};
  assign axi_raddr  = cached ? {sram_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}} : sram_addr;

  assign new_line = '{valid: 1'b1, dirty: |sram_wen, tag: addr_tag_ext};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = sweep_cnt;
    sweep_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (inv_all_req) begin
          state_next = ST_SWEEP;
          cnt_next   = '0;
        end
      end
      ST_SWEEP: begin
        sweep_clear = 1'b1;
        if (sweep_cnt == {INDEX_W{1'b1}}) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sweep_cnt + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sweep never overlaps a refill or hit: both are suppressed while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          lines[w][s] <= '0;
        end
      end
      for (int s = 0; s < SETS; s++) begin
        plru[s] <= '0;
      end
    end else begin
      if (sweep_clear) begin
        for (int w = 0; w < WAYS; w++) begin
          lines[w][sweep_cnt].valid <= 1'b0;
          lines[w][sweep_cnt].dirty <= 1'b0;
        end
      end
      if (do_refill) begin
        lines[victim][index] <= new_line;
        plru[index]          <= next_bits;
      end else if (|hit) begin
        plru[index] <= next_bits;
        if (|sram_wen) lines[hit_way][index].dirty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed bench for a 4-way, 64-set, 64-byte-line tag store with
// hand-computed PLRU victims, write-back, sweep, flush and reset cases.
module tb_cache_tag_nway;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        cached;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic        refresh;
  logic        inv_all_req;
  logic        inv_busy;
  logic        stallreq;
  logic        miss;
  logic [3:0]  hit;
  logic [1:0]  victim;
  logic [31:0] axi_raddr;
  logic        write_back;
  logic [31:0] axi_waddr;

  int checks = 0;
  int errors = 0;

  cache_tag_nway #(
    .WAYS(4), .INDEX_W(6), .OFFSET_W(6), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .cached(cached), .sram_en(sram_en),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .refresh(refresh),
    .inv_all_req(inv_all_req), .inv_busy(inv_busy), .stallreq(stallreq),
    .miss(miss), .hit(hit), .victim(victim), .axi_raddr(axi_raddr),
    .write_back(write_back), .axi_waddr(axi_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic access(input logic [31:0] addr, input logic c, input logic [3:0] wen);
    sram_addr = addr;
    cached    = c;
    sram_en   = 1'b1;
    sram_wen  = wen;
    #1;
  endtask

  // Miss on addr with the given victim, refill it, then see the new hit.
  task automatic fill(input string name, input logic [31:0] addr, input logic [1:0] exp_victim);
    access(addr, 1'b1, 4'h0);
    chk({name, "_miss"}, 32'(miss), 32'd1);
    chk({name, "_victim"}, 32'(victim), 32'(exp_victim));
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    #1;
    chk({name, "_hit"}, 32'(hit), 32'(4'b0001 << exp_victim));
    chk({name, "_nomiss"}, 32'(miss), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cached = 1'b0; sram_en = 1'b0; sram_wen = 4'h0;
    sram_addr = 32'h0; refresh = 1'b0; inv_all_req = 1'b0;
    tick();
    tick();
    chk("rst_inv_busy", 32'(inv_busy), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_write_back", 32'(write_back), 32'd0);
    chk("rst_victim", 32'(victim), 32'd0);
    chk("rst_miss_idle", 32'(miss), 32'd0);
    rst = 1'b0;
    tick();

    // First cacheable access to 0x1044: set 1, tag 1
    access(32'h0000_1044, 1'b1, 4'h0);
    chk("a1_miss", 32'(miss), 32'd1);
    chk("a1_stallreq", 32'(stallreq), 32'd1);
    chk("a1_raddr", axi_raddr, 32'h0000_1040);
    chk("a1_victim", 32'(victim), 32'd0);
    chk("a1_write_back", 32'(write_back), 32'd0);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    #1;
    chk("a1_hit", 32'(hit), 32'h1);
    chk("a1_nomiss", 32'(miss), 32'd0);
    chk("a1_nostall", 32'(stallreq), 32'd0);

    // Store hit marks way0 dirty; touching way0 again leaves PLRU as is
    access(32'h0000_1044, 1'b1, 4'hF);
    tick();
    sram_wen = 4'h0;

    fill("t2", 32'h0000_2040, 2'd2);
    fill("t3", 32'h0000_3040, 2'd1);
    fill("t4", 32'h0000_4040, 2'd3);

    // Fifth tag evicts dirty way0
    access(32'h0000_5040, 1'b1, 4'h0);
    chk("t5_miss", 32'(miss), 32'd1);
    chk("t5_victim", 32'(victim), 32'd0);
    chk("t5_write_back", 32'(write_back), 32'd1);
    chk("t5_waddr", axi_waddr, 32'h0000_1040);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    #1;
    chk("t5_hit", 32'(hit), 32'h1);
    access(32'h0000_1044, 1'b1, 4'h0);
    chk("t1_evicted_miss", 32'(miss), 32'd1);
    chk("t1_evicted_victim", 32'(victim), 32'd2);
    chk("t1_evicted_wb", 32'(write_back), 32'd0);
    chk("t1_evicted_waddr", axi_waddr, 32'h0000_2040);

    // Uncached access: no lookup, refresh ignored
    access(32'hBFD0_F004, 1'b0, 4'h0);
    chk("unc_hit", 32'(hit), 32'd0);
    chk("unc_miss", 32'(miss), 32'd0);
    chk("unc_raddr", axi_raddr, 32'hBFD0_F004);
    chk("unc_stall", 32'(stallreq), 32'd0);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    access(32'hBFD0_F004, 1'b1, 4'h0);
    chk("unc_after_miss", 32'(miss), 32'd1);
    chk("unc_after_victim", 32'(victim), 32'd0);

    // Invalidate-all sweep
    access(32'h0000_2044, 1'b1, 4'h0);
    chk("pre_sweep_hit", 32'(hit), 32'h4);
    sram_en = 1'b0;
    inv_all_req = 1'b1;
    tick();
    inv_all_req = 1'b0;
    sram_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      inv_all_req = (i == 5);
      #1;
      chk("sweep_busy", 32'(inv_busy), 32'd1);
      chk("sweep_stall", 32'(stallreq), 32'd1);
      chk("sweep_hit", 32'(hit), 32'd0);
      tick();
    end
    inv_all_req = 1'b0;
    #1;
    chk("post_sweep_busy", 32'(inv_busy), 32'd0);
    chk("post_sweep_t2_miss", 32'(miss), 32'd1);
    access(32'h0000_1044, 1'b1, 4'h0);
    chk("post_sweep_t1_miss", 32'(miss), 32'd1);
    chk("post_sweep_wb", 32'(write_back), 32'd0);

    // Flush suppresses miss, stall and write-back
    flush = 1'b1;
    #1;
    chk("flush_miss", 32'(miss), 32'd0);
    chk("flush_stall", 32'(stallreq), 32'd0);
    chk("flush_wb", 32'(write_back), 32'd0);
    flush = 1'b0;
    fill("t1_re", 32'h0000_1044, 2'd2);

    // Flushed store on a hitting line must not dirty it
    access(32'h0000_1044, 1'b1, 4'hF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sram_wen = 4'h0;
    fill("t6", 32'h0000_6040, 2'd1);
    fill("t7", 32'h0000_7040, 2'd3);
    fill("t8", 32'h0000_8040, 2'd0);
    access(32'h0000_9040, 1'b1, 4'h0);
    chk("t9_miss", 32'(miss), 32'd1);
    chk("t9_victim", 32'(victim), 32'd2);
    chk("t9_wb_clean", 32'(write_back), 32'd0);
    chk("t9_waddr", axi_waddr, 32'h0000_1040);

    // Reset in the middle of a sweep
    sram_en = 1'b0;
    inv_all_req = 1'b1;
    tick();
    inv_all_req = 1'b0;
    tick();
    tick();
    chk("mid_sweep_busy", 32'(inv_busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_sweep_busy", 32'(inv_busy), 32'd0);
    rst = 1'b0;
    access(32'h0000_6044, 1'b1, 4'h0);
    chk("rst_sweep_miss", 32'(miss), 32'd1);
    chk("rst_sweep_victim", 32'(victim), 32'd0);
    chk("rst_sweep_wb", 32'(write_back), 32'd0);
    tick();
    tick();
    chk("rst_sweep_stays_idle", 32'(inv_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
